// File: rtl/fpu_wb_pipe_pkg.sv
// fpu_pkg: shared types for the FP writeback scheduler.
// Contents: execution-class encoding, the per-stage control record
// (valid, wen, class; rd and data are carried beside it because their widths
// are module parameters), the idle record and a class-to-latency lookup.
package fpu_pkg;
    typedef enum logic [1:0] {
        FC_CVT  = 2'd0,
        FC_LOAD = 2'd1,
        FC_ADSB = 2'd2,
        FC_MUL  = 2'd3
    } fclass_e;

    typedef struct packed {
        logic    valid;
        logic    wen;
        fclass_e cls;
    } stage_ctl_t;

    localparam stage_ctl_t CTL_IDLE = '{1'b0, 1'b0, FC_CVT};

    function automatic int fc_lat(fclass_e c, int l_cvt, int l_load, int l_adsb, int l_mul);
        return c == FC_CVT ? l_cvt : c == FC_LOAD ? l_load : c == FC_ADSB ? l_adsb : l_mul;
    endfunction
endpackage

// File: rtl/fpu_wb_pipe_if.sv
// fpu_wb_pipe_if: issue / unit-result / writeback / forwarding bundle.
// master: decode side (drives issue_* and unit data, observes results).
// slave : fpu_wb_pipe (observes issue_* and unit data, drives the rest).
interface fpu_wb_pipe_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    import fpu_pkg::*;
    logic            issue_valid;
    logic            issue_ready;
    fclass_e         issue_class;
    logic            issue_wen;
    logic [RA_W-1:0] issue_rd;
    logic [RA_W-1:0] issue_rs1;
    logic [RA_W-1:0] issue_rs2;
    logic            issue_use1;
    logic            issue_use2;
    logic [XLEN-1:0] cvt_data;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] adsb_data;
    logic [XLEN-1:0] mul_data;
    logic            wb_en;
    logic [RA_W-1:0] wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            fwd1_valid;
    logic            fwd2_valid;
    logic [XLEN-1:0] fwd1_data;
    logic [XLEN-1:0] fwd2_data;
    logic            busy;

    modport master (
        output issue_valid, issue_class, issue_wen, issue_rd, issue_rs1, issue_rs2,
               issue_use1, issue_use2, cvt_data, load_data, adsb_data, mul_data,
        input  issue_ready, wb_en, wb_addr, wb_data, fwd1_valid, fwd2_valid,
               fwd1_data, fwd2_data, busy
    );
    modport slave (
        input  issue_valid, issue_class, issue_wen, issue_rd, issue_rs1, issue_rs2,
               issue_use1, issue_use2, cvt_data, load_data, adsb_data, mul_data,
        output issue_ready, wb_en, wb_addr, wb_data, fwd1_valid, fwd2_valid,
               fwd1_data, fwd2_data, busy
    );
endinterface

// File: rtl/fpu_wb_stage.sv
// fpu_wb_stage: one delay-line stage with result-capture mux, async active-low reset.
// Ports: clk, rst_n; i_ctl/i_rd/i_data = previous stage; i_cap/i_cap_data =
// unit result to load instead of i_data; o_ctl/o_rd/o_data = registered stage.
module fpu_wb_stage import fpu_pkg::*; #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  stage_ctl_t      i_ctl,
    input  logic [RA_W-1:0] i_rd,
    input  logic [XLEN-1:0] i_data,
    input  logic            i_cap,
    input  logic [XLEN-1:0] i_cap_data,
    output stage_ctl_t      o_ctl,
    output logic [RA_W-1:0] o_rd,
    output logic [XLEN-1:0] o_data
);
    stage_ctl_t      r_ctl;
    logic [RA_W-1:0] r_rd;
    logic [XLEN-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl  <= CTL_IDLE;
            r_rd   <= '0;
            r_data <= '0;
        end else begin
            r_ctl  <= i_ctl;
            r_rd   <= i_rd;
            r_data <= i_cap ? i_cap_data : i_data;
        end
    end

    assign o_ctl  = r_ctl;
    assign o_rd   = r_rd;
    assign o_data = r_data;
endmodule

// File: rtl/fpu_wb_pipe.sv
// fpu_wb_pipe: FP writeback scheduler - DEPTH-stage op delay line, per-class
// result capture, single register write port and RAW stall on issue.
// Ports: clk, rst_n (async active-low); bus = fpu_wb_pipe_if.slave.
// Option: define FPU_BYPASS_EN to forward completed in-flight results
// instead of stalling; otherwise any in-flight writer of a source stalls.
module fpu_wb_pipe import fpu_pkg::*; #(
    parameter int XLEN     = 32,
    parameter int RA_W     = 5,
    parameter int DEPTH    = 5,
    parameter int LAT_CVT  = 1,
    parameter int LAT_LOAD = 2,
    parameter int LAT_ADSB = 3,
    parameter int LAT_MUL  = 5
) (
    input logic          clk,
    input logic          rst_n,
    fpu_wb_pipe_if.slave bus
);
    stage_ctl_t      w_in_ctl  [1:DEPTH];
    logic [RA_W-1:0] w_in_rd   [1:DEPTH];
    logic [XLEN-1:0] w_in_data [1:DEPTH];
    logic            w_cap     [1:DEPTH];
    logic [XLEN-1:0] w_cap_data[1:DEPTH];
    stage_ctl_t      w_q_ctl   [1:DEPTH];
    logic [RA_W-1:0] w_q_rd    [1:DEPTH];
    logic [XLEN-1:0] w_q_data  [1:DEPTH];
    logic [XLEN-1:0] w_unit    [4];
    logic [DEPTH:1]  w_valid;
    logic [DEPTH:1]  w_m1;
    logic [DEPTH:1]  w_m2;
    logic            w_haz1;
    logic            w_haz2;
    logic            w_acc;
    logic            w_last_cap;

    function automatic int lat(fclass_e c);
        return fc_lat(c, LAT_CVT, LAT_LOAD, LAT_ADSB, LAT_MUL);
    endfunction

    assign w_unit[FC_CVT]  = bus.cvt_data;
    assign w_unit[FC_LOAD] = bus.load_data;
    assign w_unit[FC_ADSB] = bus.adsb_data;
    assign w_unit[FC_MUL]  = bus.mul_data;

    // Stalled or absent ops enter as all-zero bubbles so idle outputs stay 0.
    assign w_acc         = bus.issue_valid & bus.issue_ready;
    assign w_in_ctl[1]   = w_acc ? stage_ctl_t'{1'b1, bus.issue_wen, bus.issue_class} : CTL_IDLE;
    assign w_in_rd[1]    = w_acc ? bus.issue_rd : '0;
    assign w_in_data[1]  = '0;
    assign w_cap[1]      = 1'b0;
    assign w_cap_data[1] = '0;

    genvar k;
    for (k = 2; k <= DEPTH; k++) begin : g_link
        assign w_in_ctl[k]   = w_q_ctl[k-1];
        assign w_in_rd[k]    = w_q_rd[k-1];
        assign w_in_data[k]  = w_q_data[k-1];
        assign w_cap[k]      = w_q_ctl[k-1].valid && lat(w_q_ctl[k-1].cls) == k - 1;
        assign w_cap_data[k] = w_unit[w_q_ctl[k-1].cls];
    end

    for (k = 1; k <= DEPTH; k++) begin : g_stage
        fpu_wb_stage #(.XLEN(XLEN), .RA_W(RA_W)) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_ctl      (w_in_ctl[k]),
            .i_rd       (w_in_rd[k]),
            .i_data     (w_in_data[k]),
            .i_cap      (w_cap[k]),
            .i_cap_data (w_cap_data[k]),
            .o_ctl      (w_q_ctl[k]),
            .o_rd       (w_q_rd[k]),
            .o_data     (w_q_data[k])
        );
        assign w_valid[k] = w_q_ctl[k].valid;
    end

    // A class whose latency equals DEPTH has no later stage to capture into.
    assign w_last_cap  = w_q_ctl[DEPTH].valid && lat(w_q_ctl[DEPTH].cls) == DEPTH;
    assign bus.wb_en   = w_q_ctl[DEPTH].valid & w_q_ctl[DEPTH].wen;
    assign bus.wb_addr = w_q_rd[DEPTH];
    assign bus.wb_data = w_last_cap ? w_unit[w_q_ctl[DEPTH].cls] : w_q_data[DEPTH];
    assign bus.busy    = |w_valid;

    always_comb begin
        w_m1 = '0;
        w_m2 = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            w_m1[i] = w_q_ctl[i].valid & w_q_ctl[i].wen & (w_q_rd[i] == bus.issue_rs1);
            w_m2[i] = w_q_ctl[i].valid & w_q_ctl[i].wen & (w_q_rd[i] == bus.issue_rs2);
        end
    end

`ifdef FPU_BYPASS_EN
    logic            w_f1v;
    logic            w_f2v;
    logic [XLEN-1:0] w_f1d;
    logic [XLEN-1:0] w_f2d;

    // Walk oldest to youngest so the lowest matching stage wins (WAW order).
    always_comb begin
        w_haz1 = 1'b0;
        w_haz2 = 1'b0;
        w_f1v  = 1'b0;
        w_f2v  = 1'b0;
        w_f1d  = '0;
        w_f2d  = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            if (w_m1[i]) begin
                w_haz1 = i <= lat(w_q_ctl[i].cls);
                w_f1v  = i > lat(w_q_ctl[i].cls);
                w_f1d  = w_q_data[i];
            end
            if (w_m2[i]) begin
                w_haz2 = i <= lat(w_q_ctl[i].cls);
                w_f2v  = i > lat(w_q_ctl[i].cls);
                w_f2d  = w_q_data[i];
            end
        end
    end

    assign bus.fwd1_valid = w_f1v & bus.issue_use1;
    assign bus.fwd2_valid = w_f2v & bus.issue_use2;
    assign bus.fwd1_data  = (w_f1v & bus.issue_use1) ? w_f1d : '0;
    assign bus.fwd2_data  = (w_f2v & bus.issue_use2) ? w_f2d : '0;
`else
    assign w_haz1         = |w_m1;
    assign w_haz2         = |w_m2;
    assign bus.fwd1_valid = 1'b0;
    assign bus.fwd2_valid = 1'b0;
    assign bus.fwd1_data  = '0;
    assign bus.fwd2_data  = '0;
`endif

    assign bus.issue_ready = !((bus.issue_use1 & w_haz1) | (bus.issue_use2 & w_haz2));
endmodule

// File: tb/tb_fpu_wb_pipe.sv
// tb_fpu_wb_pipe: directed bench for fpu_wb_pipe with a writeback scoreboard.
module tb_fpu_wb_pipe;
    import fpu_pkg::*;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    localparam int LAT [4] = '{1, 2, 3, 5};
    localparam int DEPTH = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    bit   fix_on = 1'b0;
    int   fix_cyc = 0;
    wb_t  sb[$];

    fpu_wb_pipe_if #(.XLEN(32), .RA_W(5)) bus();

    fpu_wb_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] unit_val(int c, int cy);
        return (fix_on && c == 2 && cy == fix_cyc) ? 32'h4040_0000 : {4'(c + 1), 28'(cy)};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_units();
        bus.cvt_data  = unit_val(0, cyc);
        bus.load_data = unit_val(1, cyc);
        bus.adsb_data = unit_val(2, cyc);
        bus.mul_data  = unit_val(3, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        drive_units();
    endtask

    task automatic idle(int n);
        bus.issue_valid = 1'b0;
        bus.issue_use1  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic op(int cls, bit wen, int rd, int rs1, bit use1, bit exp_rdy, bit exp_fv, logic [31:0] exp_fd);
        bus.issue_valid = 1'b1;
        bus.issue_class = fclass_e'(cls);
        bus.issue_wen   = wen;
        bus.issue_rd    = 5'(rd);
        bus.issue_rs1   = 5'(rs1);
        bus.issue_use1  = use1;
        @(negedge clk);
        check("issue_ready", bus.issue_ready, exp_rdy);
        check("fwd1_valid", bus.fwd1_valid, exp_fv);
        if (exp_fv) check("fwd1_data", bus.fwd1_data, exp_fd);
        check("fwd2_valid", bus.fwd2_valid, 1'b0);
        if (exp_rdy && wen) sb.push_back('{cyc + DEPTH, 5'(rd), unit_val(cls, cyc + LAT[cls])});
        tick();
        bus.issue_valid = 1'b0;
        bus.issue_use1  = 1'b0;
    endtask

    // Writeback monitor: every write must match the oldest expectation in cycle, address and data.
    always @(negedge clk) begin
        if (chk_en) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("wb_missing_cycle", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (bus.wb_en) begin
                if (sb.size() == 0) check("wb_spurious_en", bus.wb_en, 1'b0);
                else begin
                    check("wb_cycle", cyc, sb[0].cyc);
                    check("wb_addr", bus.wb_addr, sb[0].addr);
                    check("wb_data", bus.wb_data, sb[0].data);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        logic [31:0] v;
        bus.issue_valid = 1'b0;
        bus.issue_class = FC_CVT;
        bus.issue_wen   = 1'b0;
        bus.issue_rd    = '0;
        bus.issue_rs1   = '0;
        bus.issue_rs2   = '0;
        bus.issue_use1  = 1'b0;
        bus.issue_use2  = 1'b0;
        drive_units();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wb_en", bus.wb_en, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_wb_addr", bus.wb_addr, 5'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        check("rst_fwd1_valid", bus.fwd1_valid, 1'b0);
        check("rst_ready", bus.issue_ready, 1'b1);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        // Single add/sub with a fixed result sampled three cycles after issue.
        fix_on  = 1'b1;
        fix_cyc = cyc + 3;
        op(2, 1, 3, 0, 0, 1, 0, 0);
        @(negedge clk);
        check("busy_inflight", bus.busy, 1'b1);
        idle(7);
        fix_on = 1'b0;

        // Back-to-back mul, cvt, load.
        op(3, 1, 1, 0, 0, 1, 0, 0);
        op(0, 1, 2, 0, 0, 1, 0, 0);
        op(1, 1, 4, 0, 0, 1, 0, 0);
        idle(8);

        // RAW on an add/sub result.
        t = cyc;
        op(2, 1, 7, 0, 0, 1, 0, 0);
        v = unit_val(2, t + 3);
`ifdef FPU_BYPASS_EN
        repeat (3) op(0, 0, 9, 7, 1, 0, 0, 0);
        op(0, 0, 9, 7, 1, 1, 1, v);
`else
        repeat (5) op(0, 0, 9, 7, 1, 0, 0, 0);
        op(0, 0, 9, 7, 1, 1, 0, v);
`endif
        idle(6);

        // Non-writing op is tracked but neither stalls readers nor writes.
        op(0, 0, 5, 0, 0, 1, 0, 0);
        op(0, 0, 9, 5, 1, 1, 0, 0);
        idle(7);

        // Two writers of f6; the younger cvt result is the one forwarded.
        t = cyc;
        op(3, 1, 6, 0, 0, 1, 0, 0);
        op(0, 1, 6, 0, 0, 1, 0, 0);
        v = unit_val(0, t + 2);
`ifdef FPU_BYPASS_EN
        op(0, 0, 9, 6, 1, 0, 0, 0);
        op(0, 0, 9, 6, 1, 1, 1, v);
`else
        repeat (5) op(0, 0, 9, 6, 1, 0, 0, 0);
        op(0, 0, 9, 6, 1, 1, 0, v);
`endif
        idle(8);

        // Reset with three ops in flight discards them immediately.
        op(3, 1, 1, 0, 0, 1, 0, 0);
        op(2, 1, 2, 0, 0, 1, 0, 0);
        op(1, 1, 3, 0, 0, 1, 0, 0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_wb_en", bus.wb_en, 1'b0);
        tick();
        @(negedge clk);
        check("midrst_wb_data", bus.wb_data, 32'd0);
        rst_n = 1'b1;
        tick();
        idle(7);
        @(negedge clk);
        check("postrst_busy", bus.busy, 1'b0);
        tick();

        // Pipe works again after reset.
        op(1, 1, 8, 0, 0, 1, 0, 0);
        idle(8);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
